// File: rtl/branch_resolve_unit.sv
// Dual-slot branch resolution: outcome/target, mispredict redirect,
// link writeback and a predictor-training FIFO drained by fetch.
module branch_resolve_unit #(
    parameter int XLEN     = 32,
    parameter int FB_DEPTH = 4,
    parameter int TAG_W    = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_flush,
    input  logic [1:0]            i_valid,
    input  logic [2*XLEN-1:0]     i_pc,
    input  logic [5:0]            i_funct3,
    input  logic [1:0]            i_is_jal,
    input  logic [1:0]            i_is_jalr,
    input  logic [2*XLEN-1:0]     i_rs1,
    input  logic [2*XLEN-1:0]     i_rs2,
    input  logic [2*XLEN-1:0]     i_imm,
    input  logic [1:0]            i_pred_taken,
    input  logic [2*XLEN-1:0]     i_pred_target,
    input  logic [2*TAG_W-1:0]    i_tag,
    output logic                  o_stall,
    output logic                  o_redirect_valid,
    output logic [XLEN-1:0]       o_redirect_pc,
    output logic [TAG_W-1:0]      o_redirect_tag,
    output logic [1:0]            o_link_valid,
    output logic [2*XLEN-1:0]     o_link_data,
    output logic                  o_upd_valid,
    output logic [XLEN-1:0]       o_upd_pc,
    output logic                  o_upd_taken,
    output logic [XLEN-1:0]       o_upd_target,
    output logic                  o_upd_mispredict,
    input  logic                  i_upd_ready
);

    localparam int PW = $clog2(FB_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mis;
    } upd_t;

    logic [1:0][XLEN-1:0] pc, rs1, rs2, imm;
    logic [1:0][XLEN-1:0] ptgt, tgt, nxt;
    logic [1:0][2:0]      f3;
    logic [1:0]           cond, f3_ok, jump;
    logic [1:0]           taken, train, mis;
    logic [1:0]           acc, eff;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pc[i]    = i_pc[i*XLEN +: XLEN];
            rs1[i]   = i_rs1[i*XLEN +: XLEN];
            rs2[i]   = i_rs2[i*XLEN +: XLEN];
            imm[i]   = i_imm[i*XLEN +: XLEN];
            ptgt[i]  = i_pred_target[i*XLEN +: XLEN];
            f3[i]    = i_funct3[i*3 +: 3];
            jump[i]  = i_is_jal[i] | i_is_jalr[i];
            f3_ok[i] = f3[i] inside {3'b000, 3'b001, 3'b100,
                                     3'b101, 3'b110, 3'b111};
            cond[i]  = 1'b0;
            case (f3[i])
                3'b000:  cond[i] = rs1[i] == rs2[i];
                3'b001:  cond[i] = rs1[i] != rs2[i];
                3'b100:  cond[i] = $signed(rs1[i]) < $signed(rs2[i]);
                3'b101:  cond[i] = $signed(rs1[i]) >= $signed(rs2[i]);
                3'b110:  cond[i] = rs1[i] < rs2[i];
                3'b111:  cond[i] = rs1[i] >= rs2[i];
                default: cond[i] = 1'b0;
            endcase
            tgt[i]   = pc[i] + imm[i];
            taken[i] = cond[i];
            train[i] = f3_ok[i];
            unique case (1'b1)
                i_is_jalr[i]: begin
                    tgt[i]   = (rs1[i] + imm[i]) & ~XLEN'(1);
                    taken[i] = 1'b1;
                    train[i] = 1'b1;
                end
                i_is_jal[i]: begin
                    taken[i] = 1'b1;
                    train[i] = 1'b1;
                end
                default: ;
            endcase
            nxt[i] = taken[i] ? tgt[i] : pc[i] + XLEN'(4);
            mis[i] = train[i]
                   & ((i_pred_taken[i] != taken[i])
                   | (taken[i] & (ptgt[i] != tgt[i])));
        end
    end

    // A visible redirect means this cycle's inputs are wrong-path.
    assign acc = i_valid
               & {2{~i_flush & ~o_stall & ~o_redirect_valid}};
    assign eff = {acc[1] & ~(acc[0] & mis[0]), acc[0]};

    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr, wr_ptr;
    upd_t          mem [FB_DEPTH];
    upd_t          e0, e1, head;
    logic          enq0, enq1, deq;
    logic [1:0]    n_enq;

    assign o_stall = count > CW'(FB_DEPTH - 2);
    assign enq0    = eff[0] & train[0];
    assign enq1    = eff[1] & train[1];
    assign n_enq   = {1'b0, enq0} + {1'b0, enq1};
    assign deq     = o_upd_valid & i_upd_ready;
    assign e0      = '{pc[0], taken[0], tgt[0], mis[0]};
    assign e1      = '{pc[1], taken[1], tgt[1], mis[1]};
    assign head    = mem[rd_ptr];

    assign o_upd_valid      = count != '0;
    assign o_upd_pc         = o_upd_valid ? head.pc : '0;
    assign o_upd_taken      = o_upd_valid & head.taken;
    assign o_upd_target     = o_upd_valid ? head.target : '0;
    assign o_upd_mispredict = o_upd_valid & head.mis;

    always_ff @(posedge clk) begin
        if (enq0)
            mem[wr_ptr] <= e0;
        if (enq1)
            mem[enq0 ? wr_ptr + PW'(1) : wr_ptr] <= e1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + CW'(n_enq) - CW'(deq);
            wr_ptr <= wr_ptr + PW'(n_enq);
            rd_ptr <= rd_ptr + PW'(deq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_redirect_tag   <= '0;
            o_link_valid     <= '0;
            o_link_data      <= '0;
        end else begin
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_redirect_tag   <= '0;
            if (eff[0] & mis[0]) begin
                o_redirect_valid <= 1'b1;
                o_redirect_pc    <= nxt[0];
                o_redirect_tag   <= i_tag[0 +: TAG_W];
            end else if (eff[1] & mis[1]) begin
                o_redirect_valid <= 1'b1;
                o_redirect_pc    <= nxt[1];
                o_redirect_tag   <= i_tag[TAG_W +: TAG_W];
            end
            for (int i = 0; i < 2; i++) begin
                o_link_valid[i] <= eff[i] & jump[i];
                o_link_data[i*XLEN +: XLEN] <=
                    (eff[i] & jump[i]) ? pc[i] + XLEN'(4) : '0;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit against a
// queue-based behavioural model of resolution and training.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic                 clk = 0;
    logic                 reset;
    logic                 i_flush;
    logic [1:0]           i_valid;
    logic [2*XLEN-1:0]    i_pc, i_rs1, i_rs2, i_imm, i_pred_target;
    logic [5:0]           i_funct3;
    logic [1:0]           i_is_jal, i_is_jalr, i_pred_taken;
    logic [2*TAG_W-1:0]   i_tag;
    logic                 o_stall, o_redirect_valid;
    logic [XLEN-1:0]      o_redirect_pc;
    logic [TAG_W-1:0]     o_redirect_tag;
    logic [1:0]           o_link_valid;
    logic [2*XLEN-1:0]    o_link_data;
    logic                 o_upd_valid, o_upd_taken, o_upd_mispredict;
    logic [XLEN-1:0]      o_upd_pc, o_upd_target;
    logic                 i_upd_ready;

    branch_resolve_unit #(
        .XLEN(XLEN), .FB_DEPTH(DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset), .i_flush(i_flush),
        .i_valid(i_valid), .i_pc(i_pc), .i_funct3(i_funct3),
        .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
        .i_tag(i_tag), .o_stall(o_stall),
        .o_redirect_valid(o_redirect_valid),
        .o_redirect_pc(o_redirect_pc),
        .o_redirect_tag(o_redirect_tag),
        .o_link_valid(o_link_valid), .o_link_data(o_link_data),
        .o_upd_valid(o_upd_valid), .o_upd_pc(o_upd_pc),
        .o_upd_taken(o_upd_taken), .o_upd_target(o_upd_target),
        .o_upd_mispredict(o_upd_mispredict),
        .i_upd_ready(i_upd_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        mis;
    } upd_t;

    upd_t        q[$];
    logic        m_rv;
    logic [31:0] m_rpc;
    logic [5:0]  m_rtag;
    logic [1:0]  m_lv;
    logic [31:0] m_ld[2];

    logic        s_v[2], s_jal[2], s_jalr[2], s_pt[2];
    logic [31:0] s_pc[2], s_rs1[2], s_rs2[2], s_imm[2], s_ptgt[2];
    logic [2:0]  s_f3[2];
    logic [5:0]  s_tag[2];
    logic        s_flush, s_ready;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_op(
        input  logic [31:0] pc, input logic [2:0] f3,
        input  logic jal, input logic jalr,
        input  logic [31:0] a, input logic [31:0] b,
        input  logic [31:0] imm,
        output logic tk, output logic [31:0] tgt, output logic trn);
        trn = 1;
        tgt = pc + imm;
        if (jal) tk = 1;
        else if (jalr) begin
            tk  = 1;
            tgt = (a + imm) & 32'hFFFF_FFFE;
        end else begin
            case (f3)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = (int'(a) < int'(b));
                3'd5: tk = (int'(a) >= int'(b));
                3'd6: tk = (a < b);
                3'd7: tk = (a >= b);
                default: begin tk = 0; trn = 0; end
            endcase
        end
    endfunction

    task automatic model_clear();
        q.delete();
        m_rv = 0; m_rpc = 0; m_rtag = 0; m_lv = 0;
        m_ld[0] = 0; m_ld[1] = 0;
    endtask

    task automatic idle();
        for (int s = 0; s < 2; s++) begin
            s_v[s] = 0; s_jal[s] = 0; s_jalr[s] = 0; s_pt[s] = 0;
            s_pc[s] = 0; s_rs1[s] = 0; s_rs2[s] = 0; s_imm[s] = 0;
            s_ptgt[s] = 0; s_f3[s] = 0; s_tag[s] = 0;
        end
        s_flush = 0;
    endtask

    task automatic set_op(input int s, input logic [31:0] pc,
        input logic [2:0] f3, input logic jal, input logic jalr,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] imm, input logic pt,
        input logic [31:0] ptgt, input logic [5:0] tag);
        s_v[s] = 1; s_pc[s] = pc; s_f3[s] = f3; s_jal[s] = jal;
        s_jalr[s] = jalr; s_rs1[s] = a; s_rs2[s] = b;
        s_imm[s] = imm; s_pt[s] = pt; s_ptgt[s] = ptgt;
        s_tag[s] = tag;
    endtask

    task automatic drive();
        i_flush = s_flush;
        i_upd_ready = s_ready;
        for (int s = 0; s < 2; s++) begin
            i_valid[s] = s_v[s];
            i_is_jal[s] = s_jal[s];
            i_is_jalr[s] = s_jalr[s];
            i_pred_taken[s] = s_pt[s];
            i_pc[s*32 +: 32] = s_pc[s];
            i_rs1[s*32 +: 32] = s_rs1[s];
            i_rs2[s*32 +: 32] = s_rs2[s];
            i_imm[s*32 +: 32] = s_imm[s];
            i_pred_target[s*32 +: 32] = s_ptgt[s];
            i_funct3[s*3 +: 3] = s_f3[s];
            i_tag[s*6 +: 6] = s_tag[s];
        end
    endtask

    task automatic check_outputs();
        chk("stall", o_stall, (DEPTH - q.size()) < 2);
        chk("rd_valid", o_redirect_valid, m_rv);
        chk("rd_pc", o_redirect_pc, m_rpc);
        chk("rd_tag", o_redirect_tag, m_rtag);
        chk("link_valid", o_link_valid, m_lv);
        chk("link0", o_link_data[31:0], m_ld[0]);
        chk("link1", o_link_data[63:32], m_ld[1]);
        chk("upd_valid", o_upd_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("upd_pc", o_upd_pc, q[0].pc);
            chk("upd_taken", o_upd_taken, q[0].taken);
            chk("upd_target", o_upd_target, q[0].target);
            chk("upd_mis", o_upd_mispredict, q[0].mis);
        end
    endtask

    task automatic model_advance();
        logic busy, tk, trn, mis, done;
        logic [31:0] tgt;
        busy = s_flush || ((DEPTH - q.size()) < 2) || m_rv;
        if (q.size() > 0 && s_ready) void'(q.pop_front());
        m_rv = 0; m_rpc = 0; m_rtag = 0; m_lv = 0;
        m_ld[0] = 0; m_ld[1] = 0;
        done = 0;
        for (int s = 0; s < 2; s++) begin
            if (!busy && s_v[s] && !done) begin
                ref_op(s_pc[s], s_f3[s], s_jal[s], s_jalr[s],
                       s_rs1[s], s_rs2[s], s_imm[s], tk, tgt, trn);
                mis = trn && ((s_pt[s] != tk) ||
                              (tk && s_ptgt[s] != tgt));
                if (trn) q.push_back('{s_pc[s], tk, tgt, mis});
                if (s_jal[s] || s_jalr[s]) begin
                    m_lv[s] = 1;
                    m_ld[s] = s_pc[s] + 4;
                end
                if (mis) begin
                    m_rv = 1;
                    m_rpc = tk ? tgt : s_pc[s] + 4;
                    m_rtag = s_tag[s];
                    done = 1;
                end
            end
        end
    endtask

    task automatic step();
        check_outputs();
        drive();
        model_advance();
        @(negedge clk);
    endtask

    task automatic rand_slots();
        int r;
        logic tk, trn;
        logic [31:0] tgt;
        for (int s = 0; s < 2; s++) begin
            r = $urandom % 8;
            s_v[s] = ($urandom % 4) != 0;
            s_jal[s] = (r == 0);
            s_jalr[s] = (r == 1);
            s_f3[s] = 3'($urandom);
            s_pc[s] = {$urandom % 32'h1000, 2'b00};
            s_rs1[s] = ($urandom % 2) ? $urandom : $urandom % 8;
            s_rs2[s] = ($urandom % 3 == 0) ? s_rs1[s]
                     : (($urandom % 2) ? $urandom : $urandom % 8);
            s_imm[s] = $urandom % 256 - 128;
            s_tag[s] = 6'($urandom);
            ref_op(s_pc[s], s_f3[s], s_jal[s], s_jalr[s],
                   s_rs1[s], s_rs2[s], s_imm[s], tk, tgt, trn);
            s_pt[s] = ($urandom % 4 == 0) ? !tk : tk;
            s_ptgt[s] = ($urandom % 4 == 0) ? $urandom : tgt;
        end
        s_flush = ($urandom % 10) == 0;
        s_ready = ($urandom % 4) != 0;
    endtask

    initial begin
        reset = 1;
        idle();
        s_ready = 0;
        drive();
        model_clear();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 0;
        @(negedge clk);

        // taken BEQ predicted not-taken
        set_op(0, 32'h100, 3'd0, 0, 0, 5, 5, 32'h20, 0, 0, 6'd9);
        step();
        chk("tp1_rv", o_redirect_valid, 1);
        chk("tp1_pc", o_redirect_pc, 32'h120);
        chk("tp1_tag", o_redirect_tag, 9);
        chk("tp1_upd", {o_upd_pc, o_upd_target}, {32'h100, 32'h120});
        idle();
        step();
        chk("tp1_pulse", o_redirect_valid, 0);

        // signed vs unsigned compare of the same operands
        set_op(0, 32'h200, 3'd4, 0, 0, 32'hFFFF_FFFF, 1, 8,
               1, 32'h208, 1);
        step();
        set_op(0, 32'h204, 3'd6, 0, 0, 32'hFFFF_FFFF, 1, 8,
               0, 0, 2);
        step();
        idle();
        s_ready = 1;
        step();
        step();
        step();

        // JALR + BNE in one cycle, both predicted right
        set_op(0, 32'h300, 3'd0, 0, 1, 32'h203, 0, 0,
               1, 32'h202, 3);
        set_op(1, 32'h304, 3'd1, 0, 0, 1, 2, 32'h40,
               1, 32'h344, 4);
        step();
        chk("tp3_rv", o_redirect_valid, 0);
        chk("tp3_link", o_link_data[31:0], 32'h304);
        idle();
        step();

        // BNE mispredict squashes JAL in slot 1
        set_op(0, 32'h400, 3'd1, 0, 0, 1, 2, 32'h10, 0, 0, 5);
        set_op(1, 32'h404, 3'd0, 1, 0, 0, 0, 32'h80,
               1, 32'h484, 6);
        step();
        chk("tp4_tag", o_redirect_tag, 5);
        chk("tp4_link", o_link_valid, 0);
        step();
        idle();
        step();
        step();

        // fill with ready low, then drain with concurrent enqueue
        s_ready = 0;
        for (int n = 0; n < 4; n++) begin
            set_op(0, 32'h500 + n*8, 3'd0, 0, 0, 1, 2, 4, 0, 0, 7);
            set_op(1, 32'h504 + n*8, 3'd7, 0, 0, 3, 2, 8,
                   1, 32'h50C + n*8, 8);
            step();
        end
        chk("full_stall", o_stall, 1);
        s_ready = 1;
        for (int n = 0; n < 8; n++) begin
            set_op(0, 32'h600 + n*4, 3'd5, 0, 0, 2, 1, 12,
                   1, 32'h60C + n*4, 9);
            step();
        end
        idle();
        repeat (6) step();

        for (int n = 0; n < 500; n++) begin
            rand_slots();
            step();
        end

        // asynchronous reset with entries queued
        idle();
        s_ready = 0;
        repeat (3) step();
        for (int n = 0; n < 3; n++) begin
            set_op(0, 32'h700 + n*4, 3'd0, 0, 0, 1, 1, 16,
                   1, 32'h710 + n*4, 10);
            step();
        end
        idle();
        step();
        chk("pre_rst_valid", o_upd_valid, 1);
        #2 reset = 1;
        #1;
        chk("rst_upd", o_upd_valid, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_rv", o_redirect_valid, 0);
        model_clear();
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
